shift_sequencer: RTL and testbench
==================================

// Module: shift_sequencer
// PURPOSE
//   Multi-bit shift controller that sits directly upstream of the 1-bit shifter.
//   Accepts a source word and a signed shift amount. Drives the shifter once per cycle,
//   one bit position per pass, and feeds each result back as the next operand.
//   Reports the final word with a one-cycle done pulse.
//   Supplies the datapath's multi-position shift instructions.
// PARAMETERS
//   WIDTH      16  data width; must match the 1-bit shifter
//   AMT_WIDTH  5   width of signed shift amount (two's complement, range -16..+15)
// PORTS
//   clk             in   1          system clock, all state on rising edge
//   reset           in   1          synchronous, active-high reset
//   start           in   1          request; accepted only in a cycle where ready=1
//   src             in   WIDTH      operand, sampled on accept
//   amount          in   AMT_WIDTH  signed amount: >0 left, <0 right, 0 none; sampled on accept
//   type            in   1          shift type, sampled on accept, forwarded to shifter
//   ready           out  1          1 only in IDLE
//   done            out  1          one-cycle pulse, result valid
//   result          out  WIDTH      final word; held until next accept
//   shiftSrc        out  WIDTH      operand to shifter (= internal acc)
//   shiftDirection  out  WIDTH      16'h0001 = left 1, all-ones = right 1, 0 = pass-through
//   shiftType       out  1          latched type
//   shiftIn         in   WIDTH      shifter output, captured into acc
// BEHAVIOUR
//   Registers
//     acc[WIDTH], cnt[AMT_WIDTH] (unsigned magnitude), dir (1=right),
//     typ, result, state{IDLE,SHIFT,DONE}.
//   Reset (sync, highest priority, also mid-operation)
//     state=IDLE, acc=0, cnt=0, dir=0, typ=0, result=0, done=0.
//     ready=1 in the first cycle after reset deasserts.
//     No done pulse is produced for an aborted operation.
//   IDLE
//     ready=1, shiftDirection=0.
//     start=1 (accept, call it cycle 0):
//       acc<=src, typ<=type, dir<=amount[MSB], cnt<=|amount| (-16 -> 16, fits 5 bits unsigned).
//       cnt==0 -> DONE; otherwise -> SHIFT.
//   SHIFT
//     ready=0. shiftSrc=acc, shiftType=typ.
//     shiftDirection = dir ? {WIDTH{1'b1}} : {{WIDTH-1{1'b0}},1'b1}.
//     Each edge: acc<=shiftIn, cnt<=cnt-1. When cnt==1 -> DONE.
//   DONE
//     ready=0, shiftDirection=0. result<=acc is loaded on the edge entering DONE,
//     so result is valid during DONE. done=1 for this single cycle. -> IDLE.
//   Latency
//     done is high in cycle N+1, where N=|amount| and cycle 0 is the accept cycle.
//     Next accept is possible at cycle N+2.
//   start while ready=0 is ignored; no queuing.
//   shiftDirection is never any value other than 0, 16'h0001 or all-ones.
//   Outside SHIFT, shiftSrc=acc and shiftType=typ (don't-care to consumer).
//   The block never computes shifts itself; the bit-level result is whatever
//   shiftIn returns, iterated N times.
// TESTING (bench instantiates the team 1-bit shifter on the shift* ports)
//   1. src=16'h00F0, amount=+4, type=1 -> shiftDirection=16'h0001 in cycles 1-4,
//      done at cycle 5, result=16'h0F00.
//   2. src=16'h8001, amount=-1, type=1 -> shiftDirection=16'hFFFF in cycle 1 only,
//      done at cycle 2, result=16'h4000.
//   3. src=16'hBEEF, amount=0 -> shiftDirection stays 0, done at cycle 1, result=16'hBEEF.
//   4. src=16'hFFFF, amount=-16 -> 16 SHIFT cycles, done at cycle 17, result=16'h0000.
//      Check cnt does not overflow.
//   5. Start amount=+8, assert start again at cycle 2 (ignored).
//      Assert reset at cycle 3 -> ready=1 next cycle, done never pulses, result=0.
//   6. Back-to-back: +3 then -2, second start held high from cycle 4.
//      -> Accepted at cycle 5. Two done pulses, 16'h0001 x3 then 16'hFFFF x2 on shiftDirection.
//      Second result correct from first result's independent src.

Source files
------------

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-position shift controller for the 1-bit shifter.
// Accepts a word and a signed amount, then drives the shifter one position per
// cycle, feeding each shifter result back as the next operand. The final word
// is reported on result together with a single-cycle done pulse.
//
// Ports
//   clk, reset      clock, synchronous active-high reset
//   start           request, accepted only while ready=1
//   src             operand, sampled on accept
//   amount          signed amount (>0 left, <0 right, 0 none), sampled on accept
//   stype           shift type, sampled on accept and forwarded to the shifter
//                   (named stype because "type" is a SystemVerilog keyword)
//   ready           high only while idle
//   done            one-cycle pulse, result valid
//   result          final word, held until the next accept
//   shiftSrc        operand to the shifter (the accumulator)
//   shiftDirection  1 = left one, all-ones = right one, 0 = pass-through
//   shiftType       latched shift type
//   shiftIn         shifter output, captured into the accumulator
module shift_sequencer #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned AMT_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     src,
  input  logic [AMT_WIDTH-1:0] amount,
  input  logic                 stype,
  output logic                 ready,
  output logic                 done,
  output logic [WIDTH-1:0]     result,
  output logic [WIDTH-1:0]     shiftSrc,
  output logic [WIDTH-1:0]     shiftDirection,
  output logic                 shiftType,
  input  logic [WIDTH-1:0]     shiftIn
);

  localparam logic [WIDTH-1:0] DIR_NONE  = '0;
  localparam logic [WIDTH-1:0] DIR_LEFT  = WIDTH'(1);
  localparam logic [WIDTH-1:0] DIR_RIGHT = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     acc;
  logic [AMT_WIDTH-1:0] cnt;
  logic                 dir;
  logic                 typ;
  logic [AMT_WIDTH-1:0] amt_mag;

  // Magnitude of the signed amount; the most negative value maps to 2^(AMT_WIDTH-1),
  // which still fits the unsigned counter.
  always_comb begin
    amt_mag = amount;
    if (amount[AMT_WIDTH-1]) begin
      amt_mag = AMT_WIDTH'((~amount) + AMT_WIDTH'(1));
    end
  end

  assign shiftSrc  = acc;
  assign shiftType = typ;

  // Sequencer state, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      acc            <= '0;
      cnt            <= '0;
      dir            <= 1'b0;
      typ            <= 1'b0;
      result         <= '0;
      done           <= 1'b0;
      ready          <= 1'b1;
      shiftDirection <= DIR_NONE;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            acc   <= src;
            typ   <= stype;
            dir   <= amount[AMT_WIDTH-1];
            cnt   <= amt_mag;
            ready <= 1'b0;
            if (amt_mag == '0) begin
              state  <= DONE;
              result <= src;
              done   <= 1'b1;
            end else begin
              state          <= SHIFT;
              shiftDirection <= amount[AMT_WIDTH-1] ? DIR_RIGHT : DIR_LEFT;
            end
          end
        end
        SHIFT: begin
          acc <= shiftIn;
          cnt <= cnt - AMT_WIDTH'(1);
          if (cnt == AMT_WIDTH'(1)) begin
            // Last pass: the shifter output is the final word.
            state          <= DONE;
            result         <= shiftIn;
            done           <= 1'b1;
            shiftDirection <= DIR_NONE;
          end else begin
            shiftDirection <= dir ? DIR_RIGHT : DIR_LEFT;
          end
        end
        DONE: begin
          state <= IDLE;
          ready <= 1'b1;
        end
        default: begin
          state          <= IDLE;
          ready          <= 1'b1;
          shiftDirection <= DIR_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Testbench for shift_sequencer: a behavioural 1-bit shifter closes the loop on
// the shift* ports, and every operation is checked cycle by cycle against a
// multi-bit shift reference computed directly from src, amount and type.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] src;
  logic [4:0]  amount;
  logic        stype;
  logic        ready;
  logic        done;
  logic [15:0] result;
  logic [15:0] shiftSrc;
  logic [15:0] shiftDirection;
  logic        shiftType;
  logic [15:0] shiftIn;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  shift_sequencer #(.WIDTH(16), .AMT_WIDTH(5)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .src            (src),
    .amount         (amount),
    .stype          (stype),
    .ready          (ready),
    .done           (done),
    .result         (result),
    .shiftSrc       (shiftSrc),
    .shiftDirection (shiftDirection),
    .shiftType      (shiftType),
    .shiftIn        (shiftIn)
  );

  // 1-bit shifter: type 1 = logical, type 0 = arithmetic on right shifts.
  always_comb begin
    shiftIn = shiftSrc;
    if (shiftDirection == 16'h0001) begin
      shiftIn = {shiftSrc[14:0], 1'b0};
    end else if (shiftDirection == 16'hFFFF) begin
      shiftIn = {shiftType ? 1'b0 : shiftSrc[15], shiftSrc[15:1]};
    end
  end

  // Reference: the word after n positions of shifting, as a single multi-bit shift.
  function automatic logic [15:0] ref_shift(input logic [15:0] s, input int n,
                                            input bit right, input logic t);
    logic signed [15:0] ss;
    ss = s;
    if (!right) return s << n;
    if (t) return s >> n;
    return ss >>> n;
  endfunction

  // One operation from the accept cycle to the first idle cycle after done.
  // Entered and left mid-cycle (at a falling edge). With early set, the next
  // request is raised during the done cycle and must not be taken until idle.
  task automatic run_op(input logic [15:0] s, input int a, input logic t,
                        input bit early, input logic [15:0] es, input int ea,
                        input logic et);
    int          n;
    bit          right;
    logic [15:0] dexp;
    logic [15:0] fin;
    right = (a < 0);
    n     = right ? -a : a;
    dexp  = right ? 16'hFFFF : 16'h0001;
    fin   = ref_shift(s, n, right, t);
    src    = s;
    amount = 5'(a);
    stype  = t;
    start  = 1'b1;
    vectors++;
    if (ready !== 1'b1) begin
      miscompares++;
      $display("FAIL accept_ready: got %b want 1", ready);
    end
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      vectors++;
      if (shiftDirection !== dexp || shiftSrc !== ref_shift(s, k - 1, right, t) ||
          shiftType !== t || done !== 1'b0 || ready !== 1'b0) begin
        miscompares++;
        $display("FAIL shift_cycle%0d: got dir=%h src=%h typ=%b done=%b rdy=%b want dir=%h src=%h typ=%b done=0 rdy=0",
                 k, shiftDirection, shiftSrc, shiftType, done, ready,
                 dexp, ref_shift(s, k - 1, right, t), t);
      end
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b1 || result !== fin || shiftDirection !== 16'h0000 || ready !== 1'b0) begin
      miscompares++;
      $display("FAIL done_cycle(src=%h amt=%0d typ=%b): got done=%b result=%h dir=%h rdy=%b want done=1 result=%h dir=0000 rdy=0",
               s, a, t, done, result, shiftDirection, ready, fin);
    end
    if (early) begin
      src    = es;
      amount = 5'(ea);
      stype  = et;
      start  = 1'b1;
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || ready !== 1'b1 || result !== fin || shiftDirection !== 16'h0000) begin
      miscompares++;
      $display("FAIL idle_after(src=%h amt=%0d): got done=%b rdy=%b result=%h dir=%h want done=0 rdy=1 result=%h dir=0000",
               s, a, done, ready, result, shiftDirection, fin);
    end
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    start  = 1'b0;
    src    = 16'h0;
    amount = 5'd0;
    stype  = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (ready !== 1'b1 || done !== 1'b0 || result !== 16'h0 || shiftSrc !== 16'h0 ||
        shiftDirection !== 16'h0 || shiftType !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got rdy=%b done=%b result=%h src=%h dir=%h typ=%b want 1 0 0000 0000 0000 0",
               ready, done, result, shiftSrc, shiftDirection, shiftType);
    end
  endtask

  task automatic test_directed();
    run_op(16'h00F0,   4, 1'b1, 1'b0, 16'h0, 0, 1'b0);
    run_op(16'h8001,  -1, 1'b1, 1'b0, 16'h0, 0, 1'b0);
    run_op(16'hBEEF,   0, 1'b0, 1'b0, 16'h0, 0, 1'b0);
    run_op(16'hFFFF, -16, 1'b1, 1'b0, 16'h0, 0, 1'b0);
    run_op(16'h8421, -16, 1'b0, 1'b0, 16'h0, 0, 1'b0);
    run_op(16'h0001,  15, 1'b0, 1'b0, 16'h0, 0, 1'b0);
  endtask

  task automatic test_abort();
    src    = 16'h1234;
    amount = 5'd8;
    stype  = 1'b0;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1;
    // cycle 2: a second request while busy must be ignored
    src    = 16'hFFFF;
    amount = 5'd1;
    start  = 1'b1;
    @(negedge clk);
    vectors++;
    if (ready !== 1'b0 || shiftDirection !== 16'h0001) begin
      miscompares++;
      $display("FAIL abort_busy: got rdy=%b dir=%h want rdy=0 dir=0001", ready, shiftDirection);
    end
    @(posedge clk);
    #1 start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (shiftSrc !== 16'h1234 << 2) begin
      miscompares++;
      $display("FAIL abort_progress: got src=%h want %h", shiftSrc, 16'h1234 << 2);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (ready !== 1'b1 || result !== 16'h0 || done !== 1'b0 || shiftSrc !== 16'h0 ||
        shiftDirection !== 16'h0) begin
      miscompares++;
      $display("FAIL abort_reset: got rdy=%b result=%h done=%b src=%h dir=%h want 1 0000 0 0000 0000",
               ready, result, done, shiftSrc, shiftDirection);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || ready !== 1'b1) begin
        miscompares++;
        $display("FAIL abort_no_done%0d: got done=%b rdy=%b want done=0 rdy=1", i, done, ready);
      end
    end
  endtask

  task automatic test_back_to_back();
    run_op(16'h0123,  3, 1'b1, 1'b1, 16'hC00C, -2, 1'b0);
    run_op(16'hC00C, -2, 1'b0, 1'b0, 16'h0, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [15:0] s;
    logic [15:0] ns;
    int          a;
    int          na;
    logic        t;
    logic        nt;
    s = 16'($urandom);
    a = int'($urandom_range(0, 31)) - 16;
    t = 1'($urandom);
    for (int i = 0; i < 40; i++) begin
      ns = 16'($urandom);
      na = int'($urandom_range(0, 31)) - 16;
      nt = 1'($urandom);
      run_op(s, a, t, ($urandom_range(0, 1) == 1), ns, na, nt);
      s = ns;
      a = na;
      t = nt;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_abort();
    test_back_to_back();
    test_random();
    start = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
